// File: rtl/fft8_frame_loader.sv
// Ping-pong serial-to-parallel loader: packs a valid/ready sample stream into
// 8-slot frames and presents them in parallel to the 8-point FFT.
module fft8_frame_loader #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] f0,
  output logic signed [DATA_W-1:0] f1,
  output logic signed [DATA_W-1:0] f2,
  output logic signed [DATA_W-1:0] f3,
  output logic signed [DATA_W-1:0] f4,
  output logic signed [DATA_W-1:0] f5,
  output logic signed [DATA_W-1:0] f6,
  output logic signed [DATA_W-1:0] f7,
  output logic [3:0]               out_len,
  output logic [CNT_W-1:0]         frame_count
);

  logic signed [DATA_W-1:0] r_bank [2][8];
  logic [3:0]               r_len  [2];
  logic [1:0]               r_full;
  logic                     r_wr_bank;
  logic                     r_rd_bank;
  logic [2:0]               r_wr_idx;
  logic [CNT_W-1:0]         r_frame_count;

  logic                     w_accept;
  logic                     w_close;
  logic                     w_drain;
  logic [1:0]               w_full_next;
  logic [3:0]               w_rd_len;
  logic signed [DATA_W-1:0] w_f [8];

  assign in_ready  = !rst && !r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];
  assign w_accept  = in_valid && in_ready;
  assign w_close   = w_accept && ((r_wr_idx == 3'd7) || in_last);
  assign w_drain   = out_valid && out_ready;

  // Fill and drain always address different banks, so both updates can land together.
  always_comb begin
    w_full_next = r_full;
    if (w_close) w_full_next[r_wr_bank] = 1'b1;
    if (w_drain) w_full_next[r_rd_bank] = 1'b0;
  end

  // Sample storage carries no reset; stale slots are hidden by the length mask.
  always_ff @(posedge clk) begin
    if (w_accept) r_bank[r_wr_bank][r_wr_idx] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full        <= 2'b00;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_idx      <= 3'd0;
      r_len[0]      <= 4'd0;
      r_len[1]      <= 4'd0;
      r_frame_count <= '0;
    end else begin
      r_full <= w_full_next;
      if (w_accept) begin
        if (w_close) begin
          r_len[r_wr_bank] <= {1'b0, r_wr_idx} + 4'd1;
          r_wr_idx         <= 3'd0;
          r_wr_bank        <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + 3'd1;
        end
      end
      if (w_drain) begin
        r_rd_bank     <= ~r_rd_bank;
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign w_rd_len    = r_len[r_rd_bank];
  assign out_len     = out_valid ? w_rd_len : 4'd0;
  assign frame_count = r_frame_count;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      assign w_f[gi] = (out_valid && (4'(gi) < w_rd_len)) ? r_bank[r_rd_bank][gi] : '0;
    end
  endgenerate

  assign f0 = w_f[0];
  assign f1 = w_f[1];
  assign f2 = w_f[2];
  assign f3 = w_f[3];
  assign f4 = w_f[4];
  assign f5 = w_f[5];
  assign f6 = w_f[6];
  assign f7 = w_f[7];

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Directed bench for fft8_frame_loader: expected frames are queued as samples
// are offered, and an independent monitor checks every delivered frame.
module tb_fft8_frame_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [9:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic signed [9:0] f0, f1, f2, f3, f4, f5, f6, f7;
  logic [3:0]        out_len;
  logic [15:0]       frame_count;

  fft8_frame_loader #(.DATA_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .f0(f0), .f1(f1), .f2(f2), .f3(f3), .f4(f4),
    .f5(f5), .f6(f6), .f7(f7), .out_len(out_len), .frame_count(frame_count)
  );

  typedef struct packed {
    logic [3:0]      len;
    logic [7:0][9:0] s;
  } frame_t;

  frame_t exp_q[$];
  frame_t mon_e;
  int     checks = 0;
  int     errors = 0;
  int     st;
  int     stall_total;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int len, input int a0, input int a1, input int a2,
                            input int a3, input int a4, input int a5, input int a6,
                            input int a7);
    frame_t f;
    f.len  = 4'(len);
    f.s[0] = 10'(a0); f.s[1] = 10'(a1); f.s[2] = 10'(a2); f.s[3] = 10'(a3);
    f.s[4] = 10'(a4); f.s[5] = 10'(a5); f.s[6] = 10'(a6); f.s[7] = 10'(a7);
    exp_q.push_back(f);
  endtask

  // Offers one sample from a falling edge until in_ready is seen; it is taken on the next rising edge.
  task automatic send(input int data, input bit last, input bit raise_ready, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 10'(data);
      in_last  = last;
      if (raise_ready) out_ready = 1'b1;
      #1;
      if (in_ready) done = 1'b1;
      else stalls++;
    end
    if (!done) begin
      chk("send_timeout", stalls, 0);
      in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: a frame is consumed when valid & ready are both high ahead of the rising edge.
  initial begin
    logic signed [9:0] got [8];
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame got f0=%0d len=%0d required none", f0, out_len);
        end else begin
          mon_e = exp_q.pop_front();
          got[0] = f0; got[1] = f1; got[2] = f2; got[3] = f3;
          got[4] = f4; got[5] = f5; got[6] = f6; got[7] = f7;
          chk("frame_len", out_len, mon_e.len);
          for (int k = 0; k < 8; k++)
            chk($sformatf("frame_f%0d", k), got[k], $signed(mon_e.s[k]));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1: reset state, then one full frame streamed with the consumer ready
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_f0", f0, 0);
    chk("rst_f7", f7, 0);
    chk("rst_frame_count", frame_count, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t1_in_ready_after_rst", in_ready, 1);
    push_frame(8, 1, 2, 3, 4, 5, 6, 7, 8);
    stall_total = 0;
    for (int i = 1; i <= 8; i++) begin
      send(i, 1'b0, 1'b0, st);
      stall_total += st;
    end
    chk("t1_out_valid_before_close", out_valid, 0);
    idle();
    #1;
    chk("t1_latency_out_valid", out_valid, 1);
    @(negedge clk);
    #1;
    chk("t1_out_valid_after_take", out_valid, 0);
    chk("t1_frame_count", frame_count, 1);
    chk("t1_stalls", stall_total, 0);

    // 2: consumer stalled, both banks fill, 17th sample waits
    out_ready = 1'b0;
    push_frame(8, 0, 1, 2, 3, 4, 5, 6, 7);
    push_frame(8, 8, 9, 10, 11, 12, 13, 14, 15);
    stall_total = 0;
    for (int i = 0; i < 16; i++) begin
      send(i, 1'b0, 1'b0, st);
      stall_total += st;
    end
    chk("t2_stalls_first16", stall_total, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 10'sd16; in_last = 1'b1;
    #1;
    chk("t2_in_ready_both_full", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("t2_hold_out_valid", out_valid, 1);
      chk("t2_hold_f3", f3, 3);
      chk("t2_hold_f7", f7, 7);
      chk("t2_hold_len", out_len, 8);
      chk("t2_hold_in_ready", in_ready, 0);
    end
    push_frame(1, 16, 0, 0, 0, 0, 0, 0, 0);
    send(16, 1'b1, 1'b1, st);
    chk("t2_17th_stalls", st, 1);
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("t2_frame_count", frame_count, 4);

    // 3: short frame closed by in_last, extreme values, then a fresh full frame
    push_frame(3, -512, 511, -1, 0, 0, 0, 0, 0);
    push_frame(8, 20, 21, 22, 23, 24, 25, 26, 27);
    send(-512, 1'b0, 1'b0, st);
    send(511, 1'b0, 1'b0, st);
    send(-1, 1'b1, 1'b0, st);
    for (int i = 20; i < 28; i++) send(i, 1'b0, 1'b0, st);
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("t3_frame_count", frame_count, 6);

    // 4: reset with one held frame and a partial frame pending
    out_ready = 1'b0;
    for (int i = 30; i < 38; i++) send(i, 1'b0, 1'b0, st);
    for (int i = 40; i < 45; i++) send(i, 1'b0, 1'b0, st);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t4_in_ready_in_rst", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_out_valid", out_valid, 0);
    chk("t4_out_len", out_len, 0);
    chk("t4_f0", f0, 0);
    chk("t4_frame_count", frame_count, 0);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_queue_empty", exp_q.size(), 0);
    out_ready = 1'b1;
    push_frame(8, 10, 11, 12, 13, 14, 15, 16, 17);
    for (int i = 10; i < 18; i++) send(i, 1'b0, 1'b0, st);
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("t4_frame_count_after", frame_count, 1);

    // 5: drain of bank 0 coincides with close of bank 1, then wrap of the counter
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    push_frame(8, 100, 101, 102, 103, 104, 105, 106, 107);
    push_frame(8, 110, 111, 112, 113, 114, 115, 116, 117);
    push_frame(8, 120, 121, 122, 123, 124, 125, 126, 127);
    stall_total = 0;
    for (int i = 100; i < 108; i++) begin send(i, 1'b0, 1'b0, st); stall_total += st; end
    for (int i = 110; i < 117; i++) begin send(i, 1'b0, 1'b0, st); stall_total += st; end
    send(117, 1'b0, 1'b1, st);
    stall_total += st;
    for (int i = 120; i < 128; i++) begin send(i, 1'b0, 1'b0, st); stall_total += st; end
    chk("t5_stalls", stall_total, 0);
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("t5_frame_count", frame_count, 3);

    @(negedge clk);
    force dut.r_frame_count = 16'hFFFF;
    #1;
    release dut.r_frame_count;
    #1;
    chk("t5_preload", frame_count, 65535);
    push_frame(8, -5, -4, -3, -2, -1, 0, 1, 2);
    for (int i = -5; i < 3; i++) send(i, 1'b0, 1'b0, st);
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("t5_wrap", frame_count, 0);

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
